multdiv_seq_ctrl: RTL and testbench

//  Sequencer for the multi-cycle multiplier/divider unit in the CPU's execute path.
//  - Detects R-type mul/div.
//  - Pulses the unit's start control and stalls the front end until the result is ready.
//  - Issues a one-cycle register-file write: the result to rd, or the exception code to $rstatus.

---
 rtl/multdiv_seq_ctrl_pkg.sv | 24 ++
 rtl/multdiv_seq_ctrl_cycle_counter.sv | 35 +++
 rtl/multdiv_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_multdiv_seq_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_seq_ctrl_pkg.sv
// Shared constants and state encoding for the multiply/divide sequencer.
package multdiv_seq_ctrl_pkg;

    localparam logic [4:0]  OP_RTYPE    = 5'b00000;
    localparam logic [4:0]  ALU_MUL     = 5'b00110;
    localparam logic [4:0]  ALU_DIV     = 5'b00111;
    localparam logic [4:0]  REG_RSTATUS = 5'd30;
    localparam logic [31:0] EXC_MUL     = 32'd4;
    localparam logic [31:0] EXC_DIV     = 32'd5;

    localparam int MD_MAX_CYCLES = 40;
    localparam int MD_CNT_W      = 6;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_WB   = 2'd2
    } md_state_e;

    function automatic logic [31:0] md_exc_code(input logic op_div);
        return op_div ? EXC_DIV : EXC_MUL;
    endfunction

endpackage

// File: rtl/multdiv_seq_ctrl_cycle_counter.sv
// Up-counter of cycles spent waiting on the multdiv unit; saturates at the
// timeout value so a stuck unit can never wrap back into a short count.
module md_cycle_counter #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] count_q, count_d;

    assign tc_o = (count_q == CNT_W'(MAX_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !tc_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Sequencer for the multi-cycle mul/div unit: start pulse, front-end stall,
// and a single register-file write of either the result or an exception code.
//   state | meaning
//   IDLE  | sampling decode; stalls combinationally when a mul/div is seen
//   BUSY  | start pulse in first cycle, waiting for md_ready or timeout
//   WB    | one-cycle write-back, stall released so the instruction retires
module multdiv_seq_ctrl
    import multdiv_seq_ctrl_pkg::*;
#(
    parameter int MAX_CYCLES = MD_MAX_CYCLES,
    parameter int CNT_W      = MD_CNT_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  opCode,
    input  logic [4:0]  aluOp,
    input  logic [4:0]  rd,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        busy,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data
);

    md_state_e   state_q, state_d;
    logic        op_div_q, op_div_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        ctrl_mult_q, ctrl_mult_d;
    logic        ctrl_div_q, ctrl_div_d;

    logic is_mul, is_div, tc, ready_seen, stall_c;

    assign is_mul = (opCode == OP_RTYPE) && (aluOp == ALU_MUL);
    assign is_div = (opCode == OP_RTYPE) && (aluOp == ALU_DIV);

    // The start pulse marks the first BUSY cycle, where md_ready is stale.
    assign ready_seen = md_ready && !(ctrl_mult_q || ctrl_div_q);

    md_cycle_counter #(
        .MAX_CYCLES(MAX_CYCLES),
        .CNT_W     (CNT_W)
    ) u_cycle_counter (
        .clock_i(clock),
        .reset_i(reset),
        .clr_i  (state_q != MD_BUSY),
        .en_i   (state_q == MD_BUSY),
        .tc_o   (tc)
    );

    always_comb begin
        state_d     = state_q;
        op_div_d    = op_div_q;
        rd_d        = rd_q;
        result_d    = result_q;
        exc_d       = exc_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        stall_c     = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (is_mul || is_div) begin
                    stall_c     = 1'b1;
                    op_div_d    = is_div;
                    rd_d        = rd;
                    ctrl_mult_d = is_mul;
                    ctrl_div_d  = is_div;
                    state_d     = MD_BUSY;
                end
            end
            MD_BUSY: begin
                stall_c = 1'b1;
                if (ready_seen || tc) begin
                    result_d = md_result;
                    exc_d    = ready_seen ? md_exception : 1'b1;
                    state_d  = MD_WB;
                end
            end
            MD_WB: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= MD_IDLE;
            op_div_q    <= 1'b0;
            rd_q        <= '0;
            result_q    <= '0;
            exc_q       <= 1'b0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_div_q    <= op_div_d;
            rd_q        <= rd_d;
            result_q    <= result_d;
            exc_q       <= exc_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
        end
    end

    assign ctrl_MULT = ctrl_mult_q;
    assign ctrl_DIV  = ctrl_div_q;
    assign stall     = stall_c && !reset;
    assign busy      = (state_q != MD_IDLE);

    always_comb begin
        wb_en   = 1'b0;
        wb_reg  = '0;
        wb_data = '0;
        if (state_q == MD_WB) begin
            if (exc_q) begin
                wb_en   = 1'b1;
                wb_reg  = REG_RSTATUS;
                wb_data = md_exc_code(op_div_q);
            end else begin
                wb_en   = (rd_q != 5'd0);
                wb_reg  = rd_q;
                wb_data = result_q;
            end
        end
        // An op cut short by reset must never reach the register file.
        if (reset) begin
            wb_en = 1'b0;
        end
    end

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Scoreboard bench for multdiv_seq_ctrl: driver pushes expected write-backs,
// a negedge monitor pops and compares whenever the DUT is in its WB cycle.
module tb_multdiv_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  opCode = 5'd0;
    logic [4:0]  aluOp = 5'd0;
    logic [4:0]  rd = 5'd0;
    logic        md_ready = 1'b0;
    logic        md_exception = 1'b0;
    logic [31:0] md_result = 32'd0;
    logic        ctrl_MULT, ctrl_DIV, stall, busy, wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    typedef struct {
        logic        en;
        logic [4:0]  rg;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    multdiv_seq_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .opCode      (opCode),
        .aluOp       (aluOp),
        .rd          (rd),
        .md_ready    (md_ready),
        .md_exception(md_exception),
        .md_result   (md_result),
        .ctrl_MULT   (ctrl_MULT),
        .ctrl_DIV    (ctrl_DIV),
        .stall       (stall),
        .busy        (busy),
        .wb_en       (wb_en),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: the WB cycle is the only cycle with busy high and stall low.
    always @(negedge clock) begin
        if (!reset && busy && !stall) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'(wb_en), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_en", 32'(wb_en), 32'(e.en));
                chk("wb_reg", 32'(wb_reg), 32'(e.rg));
                chk("wb_data", wb_data, e.data);
                chk("wb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (!reset) begin
            chk("wb_quiet", {wb_en, 26'd0, wb_reg} | wb_data, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // n_ready = BUSY cycle index where md_ready rises and stays high; 0 = never.
    task automatic run_op(input logic is_div, input logic [4:0] rd_v, input int n_ready,
                          input logic exc, input logic [31:0] res);
        exp_t e;
        int   lat;
        int   n_stall;
        bit   done;
        opCode       = 5'b00000;
        aluOp        = is_div ? 5'b00111 : 5'b00110;
        rd           = rd_v;
        md_ready     = 1'b0;
        md_exception = 1'b0;
        md_result    = 32'hDEAD_BEEF;
        lat = (n_ready == 0) ? 40 : ((n_ready < 2) ? 2 : n_ready);
        e.cyc = cyc + lat + 1;
        if (n_ready == 0 || exc) begin
            e.en   = 1'b1;
            e.rg   = 5'd30;
            e.data = is_div ? 32'd5 : 32'd4;
        end else begin
            e.en   = (rd_v != 5'd0);
            e.rg   = rd_v;
            e.data = res;
        end
        sb.push_back(e);
        @(negedge clock);
        chk("detect_stall", 32'(stall), 32'd1);
        n_stall = 1;
        done    = 1'b0;
        tick();
        for (int k = 1; k <= 45 && !done; k++) begin
            if (n_ready != 0 && k >= n_ready) begin
                md_ready     = 1'b1;
                md_exception = exc;
                md_result    = res;
            end
            @(negedge clock);
            if (k == 1) begin
                chk("start_mult", 32'(ctrl_MULT), 32'(!is_div));
                chk("start_div", 32'(ctrl_DIV), 32'(is_div));
            end else if (k == 2) begin
                chk("start_one_cycle", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
            end
            if (stall) n_stall++;
            else done = 1'b1;
            tick();
        end
        chk("stall_cycles", 32'(n_stall), 32'(lat + 1));
        aluOp = 5'd0;
        rd    = 5'd0;
    endtask

    task automatic idle(input int n, input logic [4:0] op, input logic [4:0] alu);
        opCode = op;
        aluOp  = alu;
        rd     = 5'd6;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aluOp = 5'b00110;
        repeat (3) begin
            @(negedge clock);
            chk("reset_stall", 32'(stall), 32'd0);
            tick();
        end
        reset = 1'b0;
        aluOp = 5'd0;
        @(negedge clock);
        chk("reset_outputs", {26'd0, ctrl_MULT, ctrl_DIV, stall, busy, wb_en, 1'b0}, 32'd0);
        tick();

        run_op(1'b0, 5'd3, 32, 1'b0, 32'd12);
        run_op(1'b1, 5'd5, 6, 1'b1, 32'd99);
        idle(2, 5'd0, 5'd0);
        run_op(1'b0, 5'd0, 4, 1'b0, 32'd7);
        run_op(1'b0, 5'd7, 0, 1'b0, 32'd0);

        opCode   = 5'd0;
        aluOp    = 5'b00110;
        rd       = 5'd4;
        md_ready = 1'b0;
        @(negedge clock);
        chk("mid_detect_stall", 32'(stall), 32'd1);
        repeat (6) tick();
        reset = 1'b1;
        @(negedge clock);
        chk("mid_reset_stall", 32'(stall), 32'd0);
        tick();
        reset = 1'b0;
        aluOp = 5'd0;
        @(negedge clock);
        chk("post_reset_outputs", {26'd0, ctrl_MULT, ctrl_DIV, stall, busy, wb_en, 1'b0}, 32'd0);
        tick();
        idle(2, 5'd0, 5'd0);
        run_op(1'b0, 5'd9, 3, 1'b0, 32'h1234_5678);

        run_op(1'b0, 5'd10, 2, 1'b0, 32'd100);
        run_op(1'b1, 5'd11, 2, 1'b0, 32'd3);
        idle(3, 5'd0, 5'd0);
        idle(2, 5'd1, 5'b00110);
        run_op(1'b1, 5'd12, 1, 1'b0, 32'd55);
        run_op(1'b1, 5'd13, 40, 1'b0, 32'hFFFF_FFFF);
        idle(2, 5'd0, 5'd0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
